// File: rtl/alu_seq_unit_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM state encoding
// and default widths.
package alu_seq_unit_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned SHW_DEFAULT        = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath. Shift ops return a unchanged, which is the
// correct result for a zero shift amount; non-zero shifts run in the sequencer.
module alu_comb_core
  import alu_seq_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = a;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLT: begin
        result    = '0;
        result[0] = ($signed(a) < $signed(b));
      end
      default: result = a;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle ops via alu_comb_core, shifts at one bit per
// cycle, valid/ready handshakes on request and response.
module alu_seq_unit
  import alu_seq_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned SHW        = SHW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [2:0]            req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  busy
);

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_t                state;
  logic [DATA_WIDTH-1:0] work;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [SHW-1:0]        cnt;
  logic [SHW-1:0]        shamt;
  logic                  dir_right;
  logic                  xfer;
  logic                  start_shift;

  assign shamt       = req_b[SHW-1:0];
  assign req_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign xfer        = req_valid && req_ready;
  assign start_shift = is_shift_op(req_op) && (shamt != '0);
  assign shifted     = dir_right ? (work >> 1) : (work << 1);

  alu_comb_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .a      (req_a),
    .b      (req_b),
    .op     (req_op),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b1;
      cnt        <= '0;
      work       <= '0;
      dir_right  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (start_shift) begin
              state     <= ST_SHIFT;
              work      <= req_a;
              cnt       <= shamt;
              dir_right <= (req_op == OP_SRL);
            end else begin
              state      <= ST_DONE;
              rsp_valid  <= 1'b1;
              rsp_result <= alu_result;
              rsp_zero   <= (alu_result == '0);
            end
          end
        end
        ST_SHIFT: begin
          work <= shifted;
          cnt  <= cnt - CNT_ONE;
          // The last shift step publishes its own output directly.
          if (cnt == CNT_ONE) begin
            state      <= ST_DONE;
            rsp_valid  <= 1'b1;
            rsp_result <= shifted;
            rsp_zero   <= (shifted == '0);
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: cycle-level reference model compared every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [2:0]  req_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  alu_seq_unit #(.DATA_WIDTH(32), .SHW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int unsigned sh;
    sh = b[4:0];
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  // Reference model: what the outputs must be after each edge
  bit          m_idle = 1'b1;
  bit          m_valid = 1'b0;
  logic [31:0] m_result = '0;
  bit          m_zero = 1'b1;
  logic [31:0] m_pend = '0;
  int          m_wait = 0;
  logic [31:0] m_r;

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_valid = 1'b0; m_result = '0; m_zero = 1'b1; m_wait = 0;
    end else if (m_idle) begin
      if (req_valid) begin
        m_r = ref_fn(req_op, req_a, req_b);
        m_idle = 1'b0;
        if (req_op[2:1] == 2'b11 && req_b[4:0] != 5'd0) begin
          m_wait = int'(req_b[4:0]);
          m_pend = m_r;
        end else begin
          m_valid = 1'b1; m_result = m_r; m_zero = (m_r == 32'd0);
        end
      end
    end else if (!m_valid) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1; m_result = m_pend; m_zero = (m_pend == 32'd0);
      end
    end else if (rsp_ready) begin
      m_valid = 1'b0; m_idle = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_req_ready", {31'd0, req_ready}, {31'd0, m_idle});
      chk("cyc_busy", {31'd0, busy}, {31'd0, !m_idle});
      chk("cyc_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      chk("cyc_rsp_result", rsp_result, m_result);
      chk("cyc_rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input logic [31:0] lit,
                       input bit lit_zero, input int lat);
    int n;
    wait_idle();
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
    n = 1;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_latency"}, n, lat);
    chk({name, "_result"}, rsp_result, lit);
    chk({name, "_zero"}, {31'd0, rsp_zero}, {31'd0, lit_zero});
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      chk({name, "_held_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({name, "_held_result"}, rsp_result, lit);
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  logic [31:0] corner [4] = '{32'h0000_0000, 32'hffff_ffff, 32'h8000_0000, 32'h7fff_ffff};

  initial begin
    int seen;
    logic [2:0]  op;
    logic [31:0] a, b, r;
    int lat;

    rst = 1'b1;
    @(posedge clk); #1;
    check_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_result", rsp_result, 32'd0);
    chk("reset_zero", {31'd0, rsp_zero}, 32'd1);

    do_op("add", 3'd0, 32'h00ff_ff00, 32'hffff_ffae, 0, 32'h00ff_feae, 1'b0, 1);
    do_op("sub", 3'd1, 32'h0aeb_c234, 32'h0aeb_c234, 0, 32'h0000_0000, 1'b1, 1);
    do_op("slt", 3'd5, 32'hffff_ffff, 32'h0000_0001, 0, 32'h0000_0001, 1'b0, 1);
    do_op("sll31", 3'd6, 32'h0000_0001, 32'h0000_001f, 0, 32'h8000_0000, 1'b0, 32);
    do_op("srl4", 3'd7, 32'hf000_0000, 32'h0000_0004, 0, 32'h0f00_0000, 1'b0, 5);
    do_op("and_bp", 3'd2, 32'hf0f0_f0f0, 32'hffff_0000, 10, 32'hf0f0_0000, 1'b0, 1);
    do_op("sll0", 3'd6, 32'h1234_5678, 32'hffff_ffe0, 1, 32'h1234_5678, 1'b0, 1);
    do_op("xor", 3'd4, 32'hffff_ffff, 32'h7fff_ffff, 0, 32'h8000_0000, 1'b0, 1);

    // Reset in the middle of a 20-bit shift
    wait_idle();
    req_op = 3'd6; req_a = 32'h0000_0003; req_b = 32'd20; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_result", rsp_result, 32'd0);
    chk("midrst_zero", {31'd0, rsp_zero}, 32'd1);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("midrst_no_response", seen, 0);

    for (int unsigned i = 0; i < 48; i++) begin
      op = 3'(i % 8);
      a = ($urandom_range(0, 4) == 4) ? $urandom : corner[$urandom_range(0, 3)];
      case ($urandom_range(0, 3))
        0: b = {$urandom} & 32'hffff_ffe0;
        1: b = {$urandom} | 32'h0000_001f;
        2: b = corner[$urandom_range(0, 3)];
        default: b = $urandom;
      endcase
      r = ref_fn(op, a, b);
      lat = (op[2:1] == 2'b11 && b[4:0] != 5'd0) ? int'(b[4:0]) + 1 : 1;
      do_op("rand", op, a, b, $urandom_range(0, 3), r, (r == 32'd0), lat);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter SHW, default 5, equal to log2(DATA_WIDTH) and giving the shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_a  input  DATA_WIDTH  operand a.
REQ-008 req_b  input  DATA_WIDTH  operand b; bits [SHW-1:0] are the shift amount for shift ops.
REQ-009 req_op  input  3  operation code.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer takes the result this cycle.
REQ-012 rsp_result  output  DATA_WIDTH  result.
REQ-013 rsp_zero  output  1  high when rsp_result is all zeros.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Op encoding SHALL be: 000 ADD; 001 SUB (a-b); 010 AND; 011 OR; 100 XOR; 101 SLT (signed a<b yields 1, else 0); 110 SLL (a<<shamt); 111 SRL (logical a>>shamt).
REQ-016 ADD and SUB SHALL wrap modulo 2^DATA_WIDTH, with the carry and borrow discarded.
REQ-017 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-018 req_ready SHALL equal (state==IDLE); a transfer occurs on a cycle where req_valid and req_ready are both high.
REQ-019 On a transfer the block SHALL register a, b(shamt) and op; req_* are ignored at all other times.
REQ-020 Ops 000-101, and shift ops with shamt==0, SHALL compute in the transfer cycle and enter DONE: rsp_valid is high on the cycle after the transfer (latency 1).
REQ-021 A shift op with shamt>0 SHALL enter SHIFT, load a into a working register and load shamt into a down-counter.
REQ-022 In SHIFT the block SHALL shift the working register by one bit per cycle and decrement the counter.
REQ-023 The block SHALL leave SHIFT for DONE when the counter reaches 1, after which rsp_valid is high; total latency from transfer to rsp_valid is shamt+1 cycles.
REQ-024 In DONE, rsp_valid SHALL be high and rsp_result/rsp_zero SHALL be held stable until rsp_ready is sampled high.
REQ-025 When rsp_ready is high in DONE, the block SHALL go to IDLE on the next edge; minimum issue interval is 2 cycles.
REQ-026 rsp_valid SHALL be low in IDLE and SHIFT; rsp_result SHALL keep its last value outside DONE.
REQ-027 Shift with shamt=DATA_WIDTH-1 SHALL complete in DATA_WIDTH cycles; the counter SHALL be SHW bits and never wrap.
REQ-028 rsp_ready asserted outside DONE SHALL have no effect.

Reset
REQ-029 rst high SHALL force state=IDLE, rsp_valid=0, rsp_result=0, rsp_zero=1, busy=0, and counter=0 on the next edge, in any state.
REQ-030 Reset during SHIFT or DONE SHALL discard the pending operation; no response is produced.
REQ-031 req_ready SHALL be high on the first cycle after rst deasserts.

Structure
REQ-032 A shared package SHALL hold the op-code constants (OP_ADD..OP_SRL), the state encoding and DATA_WIDTH's default.
REQ-033 Combinational single-cycle ops SHALL live in one sub-module, alu_comb_core (inputs a, b, op; output result); the shifter and the FSM stay in alu_seq_unit.
REQ-034 All registers SHALL be in one clk-edge process; there SHALL be no latches and no asynchronous paths from rst.

Verification
REQ-035 ADD a=00ffff00, b=ffffffae, rsp_ready=1 -> rsp_valid 1 cycle after transfer, result 00fffeae, zero=0; req_ready low while busy.
REQ-036 SUB a=0aebc234, b=0aebc234 -> result 00000000, zero=1; SLT a=ffffffff, b=00000001 -> result 00000001.
REQ-037 SLL a=00000001, b=0000001f -> rsp_valid exactly 32 cycles after transfer, result 80000000; SRL a=f0000000, b=00000004 -> 5 cycles, result 0f000000.
REQ-038 Backpressure: AND a=f0f0f0f0, b=ffff0000 with rsp_ready held low 10 cycles -> rsp_valid and result f0f00000 stable throughout, req_ready low; accepted the cycle rsp_ready rises, req_ready high on the next cycle.
REQ-039 Reset mid-SHIFT: SLL shamt=20, rst pulsed at cycle 5 -> next cycle state IDLE, rsp_valid=0, result=0, zero=1, and no response ever appears for that request.
REQ-040 A randomized bench SHALL compare every response against a reference model for all 8 ops, with shamt 0 and DATA_WIDTH-1 and operands 0, ffffffff, 80000000 and 7fffffff.
